// File: rtl/rv_pkg.sv
// Shared register-file constants and the buffered write-back entry format.
package rv_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam logic [ADDR_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic              live;
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Circular buffer of pending load results with kill-by-register and
// register-match lookups for hazard detection.
module wb_fifo
    import rv_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push_en,
    input  logic [ADDR_W-1:0]      push_rd,
    input  logic [DATA_W-1:0]      push_data,
    input  logic                   pop_en,
    input  logic                   kill_en,
    input  logic [ADDR_W-1:0]      kill_rd,
    input  logic [ADDR_W-1:0]      q_rs1,
    input  logic [ADDR_W-1:0]      q_rs2,
    output wb_entry_t              head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   match_rs1,
    output logic                   match_rs2
);

    localparam int PTR_W = $clog2(DEPTH);

    wb_entry_t              mem_q [DEPTH];
    logic [PTR_W-1:0]       rd_ptr_q;
    logic [PTR_W-1:0]       wr_ptr_q;
    logic [$clog2(DEPTH):0] count_q;

    // live is cleared on pop as well, so unoccupied slots never match a lookup
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (kill_en && mem_q[i].rd == kill_rd) begin
                    mem_q[i].live <= 1'b0;
                end
            end
            if (pop_en) begin
                mem_q[rd_ptr_q].live <= 1'b0;
                rd_ptr_q             <= rd_ptr_q + 1'b1;
            end
            if (push_en) begin
                mem_q[wr_ptr_q] <= '{live: 1'b1, rd: push_rd, data: push_data};
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            case ({push_en, pop_en})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_comb begin
        match_rs1 = 1'b0;
        match_rs2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (mem_q[i].live && mem_q[i].rd == q_rs1) match_rs1 = 1'b1;
            if (mem_q[i].live && mem_q[i].rd == q_rs2) match_rs2 = 1'b1;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/regfile_writeback.sv
// Register-file write port driver: ALU results take priority over buffered
// load results, with write-after-write kill of stale loads.
module regfile_writeback
    import rv_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   alu_valid,
    input  logic [ADDR_W-1:0]      alu_rd,
    input  logic [DATA_W-1:0]      alu_data,
    input  logic                   mem_valid,
    output logic                   mem_ready,
    input  logic [ADDR_W-1:0]      mem_rd,
    input  logic [DATA_W-1:0]      mem_data,
    output logic                   alu_stall,
    input  logic [ADDR_W-1:0]      query_rs1,
    input  logic [ADDR_W-1:0]      query_rs2,
    output logic                   busy_rs1,
    output logic                   busy_rs2,
    output logic                   regwrite,
    output logic [ADDR_W-1:0]      write_reg,
    output logic [DATA_W-1:0]      write_data,
    output logic [$clog2(DEPTH):0] fifo_count
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    wb_entry_t         head;
    logic [CNT_W-1:0]  count;
    logic              match_rs1;
    logic              match_rs2;
    logic              alu_sel;
    logic              accept;
    logic              push_en;
    logic              pop_en;

    logic              regwrite_q,   regwrite_d;
    logic [ADDR_W-1:0] write_reg_q,  write_reg_d;
    logic [DATA_W-1:0] write_data_q, write_data_d;

    assign mem_ready = (count < CNT_W'(DEPTH));
    assign alu_stall = (count == CNT_W'(DEPTH));
    assign alu_sel   = alu_valid && (alu_rd != REG_ZERO);
    assign accept    = mem_valid && mem_ready;
    // A load accepted alongside a same-register ALU result is already stale
    assign push_en   = accept && (mem_rd != REG_ZERO) && !(alu_sel && mem_rd == alu_rd);
    assign pop_en    = !alu_sel && (count != '0);

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push_en   (push_en),
        .push_rd   (mem_rd),
        .push_data (mem_data),
        .pop_en    (pop_en),
        .kill_en   (alu_sel),
        .kill_rd   (alu_rd),
        .q_rs1     (query_rs1),
        .q_rs2     (query_rs2),
        .head      (head),
        .count     (count),
        .match_rs1 (match_rs1),
        .match_rs2 (match_rs2)
    );

    always_comb begin
        regwrite_d   = 1'b0;
        write_reg_d  = write_reg_q;
        write_data_d = write_data_q;
        if (alu_sel) begin
            regwrite_d   = 1'b1;
            write_reg_d  = alu_rd;
            write_data_d = alu_data;
        end else if (pop_en && head.live) begin
            regwrite_d   = 1'b1;
            write_reg_d  = head.rd;
            write_data_d = head.data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            regwrite_q   <= 1'b0;
            write_reg_q  <= '0;
            write_data_q <= '0;
        end else begin
            regwrite_q   <= regwrite_d;
            write_reg_q  <= write_reg_d;
            write_data_q <= write_data_d;
        end
    end

    assign busy_rs1 = (query_rs1 != REG_ZERO) &&
                      (match_rs1 || (regwrite_q && write_reg_q == query_rs1));
    assign busy_rs2 = (query_rs2 != REG_ZERO) &&
                      (match_rs2 || (regwrite_q && write_reg_q == query_rs2));

    assign regwrite   = regwrite_q;
    assign write_reg  = write_reg_q;
    assign write_data = write_data_q;
    assign fifo_count = count;

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed vector bench for regfile_writeback: per-cycle stimulus table with
// expected outputs, plus a hand-written asynchronous reset-mid-drain sequence.
module tb_regfile_writeback;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        alu_valid = 1'b0;
    logic [4:0]  alu_rd = '0;
    logic [31:0] alu_data = '0;
    logic        mem_valid = 1'b0;
    logic        mem_ready;
    logic [4:0]  mem_rd = '0;
    logic [31:0] mem_data = '0;
    logic        alu_stall;
    logic [4:0]  query_rs1 = '0;
    logic [4:0]  query_rs2 = '0;
    logic        busy_rs1;
    logic        busy_rs2;
    logic        regwrite;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic [2:0]  fifo_count;

    int tests = 0;
    int fails = 0;

    regfile_writeback #(.DEPTH(4)) dut (
        .clock      (clock),
        .reset      (reset),
        .alu_valid  (alu_valid),
        .alu_rd     (alu_rd),
        .alu_data   (alu_data),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_rd     (mem_rd),
        .mem_data   (mem_data),
        .alu_stall  (alu_stall),
        .query_rs1  (query_rs1),
        .query_rs2  (query_rs2),
        .busy_rs1   (busy_rs1),
        .busy_rs2   (busy_rs2),
        .regwrite   (regwrite),
        .write_reg  (write_reg),
        .write_data (write_data),
        .fifo_count (fifo_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] av, ard, adata, mv, mrd, mdata, q1, q2;
        logic [31:0] e_rw, chk_w, e_wr, e_wd, e_cnt, e_rdy, e_stall, e_b1, e_b2;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [31:0] av, ard, adata, mv, mrd, mdata, q1, q2,
                       input logic [31:0] e_rw, chk_w, e_wr, e_wd, e_cnt, e_rdy,
                       input logic [31:0] e_stall, e_b1, e_b2);
        vec_t v;
        v = '{av, ard, adata, mv, mrd, mdata, q1, q2,
              e_rw, chk_w, e_wr, e_wd, e_cnt, e_rdy, e_stall, e_b1, e_b2};
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
        query_rs1 = '0;   query_rs2 = '0;
    endtask

    initial begin
        //   av rd adata         mv mrd mdata  q1 q2 | rw chk wr wd           cnt rdy stl b1 b2
        add(1, 3, 32'hDEADBEEF, 0, 0, 0,      3, 0,   1, 1, 3, 32'hDEADBEEF, 0, 1, 0, 1, 0);
        add(0, 0, 0,            0, 0, 0,      3, 0,   0, 0, 0, 0,            0, 1, 0, 0, 0);
        add(1, 0, 5,            0, 0, 0,      0, 0,   0, 0, 0, 0,            0, 1, 0, 0, 0);
        // four loads buffered behind a busy ALU
        add(1, 20, 32'h20,      1, 5, 32'h55, 5, 20,  1, 1, 20, 32'h20,      1, 1, 0, 1, 1);
        add(1, 21, 32'h21,      1, 6, 32'h66, 6, 5,   1, 1, 21, 32'h21,      2, 1, 0, 1, 1);
        add(1, 22, 32'h22,      1, 7, 32'h77, 7, 0,   1, 1, 22, 32'h22,      3, 1, 0, 1, 0);
        add(1, 23, 32'h23,      1, 8, 32'h88, 8, 0,   1, 1, 23, 32'h23,      4, 0, 1, 1, 0);
        add(0, 0, 0,            0, 0, 0,      5, 8,   1, 1, 5, 32'h55,       3, 1, 0, 1, 1);
        add(0, 0, 0,            0, 0, 0,      0, 0,   1, 1, 6, 32'h66,       2, 1, 0, 0, 0);
        add(0, 0, 0,            0, 0, 0,      0, 0,   1, 1, 7, 32'h77,       1, 1, 0, 0, 0);
        add(0, 0, 0,            0, 0, 0,      8, 0,   1, 1, 8, 32'h88,       0, 1, 0, 1, 0);
        add(0, 0, 0,            0, 0, 0,      8, 0,   0, 0, 0, 0,            0, 1, 0, 0, 0);
        // write-after-write: buffered x9 killed by younger ALU x9
        add(0, 0, 0,            1, 9, 32'h1,  9, 0,   0, 0, 0, 0,            1, 1, 0, 1, 0);
        add(1, 9, 32'h2,        0, 0, 0,      9, 0,   1, 1, 9, 32'h2,        1, 1, 0, 1, 0);
        add(0, 0, 0,            0, 0, 0,      9, 0,   0, 0, 0, 0,            0, 1, 0, 0, 0);
        add(0, 0, 0,            0, 0, 0,      9, 0,   0, 0, 0, 0,            0, 1, 0, 0, 0);
        // same-cycle load and ALU to x4: load dropped
        add(1, 4, 32'hB,        1, 4, 32'hA,  4, 0,   1, 1, 4, 32'hB,        0, 1, 0, 1, 0);
        add(0, 0, 0,            0, 0, 0,      4, 0,   0, 0, 0, 0,            0, 1, 0, 0, 0);
        // hazard query on pending x10
        add(1, 11, 32'h11,      1, 10, 32'h10, 10, 0, 1, 1, 11, 32'h11,      1, 1, 0, 1, 0);
        add(0, 0, 0,            0, 0, 0,      10, 0,  1, 1, 10, 32'h10,      0, 1, 0, 1, 0);
        add(0, 0, 0,            0, 0, 0,      10, 0,  0, 0, 0, 0,            0, 1, 0, 0, 0);
        // load to x0 accepted but never enqueued
        add(0, 0, 0,            1, 0, 32'h7,  0, 0,   0, 0, 0, 0,            0, 1, 0, 0, 0);
        add(0, 0, 0,            0, 0, 0,      0, 0,   0, 0, 0, 0,            0, 1, 0, 0, 0);

        idle_inputs();
        repeat (2) @(negedge clock);
        check("rst.regwrite",   32'(regwrite),   0);
        check("rst.write_reg",  32'(write_reg),  0);
        check("rst.write_data", write_data,      0);
        check("rst.fifo_count", 32'(fifo_count), 0);
        reset = 1'b0;
        #1;
        check("rst.mem_ready",  32'(mem_ready),  1);
        check("rst.alu_stall",  32'(alu_stall),  0);

        foreach (vecs[i]) begin
            @(negedge clock);
            alu_valid = vecs[i].av[0];  alu_rd = vecs[i].ard[4:0];  alu_data = vecs[i].adata;
            mem_valid = vecs[i].mv[0];  mem_rd = vecs[i].mrd[4:0];  mem_data = vecs[i].mdata;
            query_rs1 = vecs[i].q1[4:0]; query_rs2 = vecs[i].q2[4:0];
            @(posedge clock);
            #1;
            check($sformatf("v%0d.regwrite", i),   32'(regwrite),   vecs[i].e_rw);
            if (vecs[i].chk_w[0]) begin
                check($sformatf("v%0d.write_reg", i),  32'(write_reg), vecs[i].e_wr);
                check($sformatf("v%0d.write_data", i), write_data,     vecs[i].e_wd);
            end
            check($sformatf("v%0d.fifo_count", i), 32'(fifo_count), vecs[i].e_cnt);
            check($sformatf("v%0d.mem_ready", i),  32'(mem_ready),  vecs[i].e_rdy);
            check($sformatf("v%0d.alu_stall", i),  32'(alu_stall),  vecs[i].e_stall);
            check($sformatf("v%0d.busy_rs1", i),   32'(busy_rs1),   vecs[i].e_b1);
            check($sformatf("v%0d.busy_rs2", i),   32'(busy_rs2),   vecs[i].e_b2);
        end

        // reset asserted mid-drain: three loads buffered, first one popped
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            alu_valid = 1'b1; alu_rd = 5'(24 + k); alu_data = 32'(k);
            mem_valid = 1'b1; mem_rd = 5'(12 + k); mem_data = 32'(32'hC0 + k);
        end
        @(negedge clock);
        idle_inputs();
        @(posedge clock);
        #1;
        check("drain.fifo_count", 32'(fifo_count), 2);
        check("drain.write_reg",  32'(write_reg),  12);
        @(negedge clock);
        #2;
        reset = 1'b1;
        #1;
        check("arst.regwrite",   32'(regwrite),   0);
        check("arst.fifo_count", 32'(fifo_count), 0);
        @(negedge clock);
        reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clock);
            #1;
            check($sformatf("post.regwrite%0d", k),   32'(regwrite),   0);
            check($sformatf("post.fifo_count%0d", k), 32'(fifo_count), 0);
            check($sformatf("post.mem_ready%0d", k),  32'(mem_ready),  1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/regfile_writeback.md
Name: regfile_writeback

Overview:
- Writer side of the 32x32 register file's single write port.
- Merges two result sources into one registered write stream:
  - ALU results: arrive every cycle, no backpressure.
  - Load results: valid/ready handshake, buffered in a small FIFO.
- Kills stale buffered loads on write-after-write and reports pending writes so hazard logic can stall reads.
- Sits between the execute/memory stages and the register file write port.

Parameters:
DEPTH, 4, load-result FIFO entries (power of 2, >=2)
DATA_W, 32, register data width
ADDR_W, 5, register number width

Ports:
clock  in  1  clock, rising edge
reset  in  1  reset, asynchronous, active-high
alu_valid  in  1  ALU result present this cycle
alu_rd  in  ADDR_W  ALU destination register
alu_data  in  DATA_W  ALU result
mem_valid  in  1  load result offered
mem_ready  out  1  load result accepted when mem_valid&&mem_ready
mem_rd  in  ADDR_W  load destination register
mem_data  in  DATA_W  load data
alu_stall  out  1  request upstream to hold ALU results so the FIFO can drain
query_rs1  in  ADDR_W  hazard query register 1
query_rs2  in  ADDR_W  hazard query register 2
busy_rs1  out  1  query_rs1 has a pending write
busy_rs2  out  1  query_rs2 has a pending write
regwrite  out  1  to register file write enable
write_reg  out  ADDR_W  to register file write address
write_data  out  DATA_W  to register file write data
fifo_count  out  $clog2(DEPTH)+1  live+dead entries held

Behaviour:
- Reset (async): regwrite=0, write_reg=0, write_data=0, FIFO emptied, fifo_count=0.
  - Mid-operation reset discards all buffered loads.
  - mem_ready=1 after release.
- regwrite, write_reg and write_data are registered. A result chosen in cycle N appears at the outputs in cycle N+1 and is written into the register file at the end of N+1.
- Writes to register 0 are never issued:
  - ALU with alu_rd=0 is treated as idle.
  - A load with mem_rd=0 is accepted (handshake completes) but not enqueued.
- FIFO entry = {live, rd, data}.
  - mem_ready = (fifo_count < DEPTH). It depends only on the registered count; a pop in the same cycle does not raise it.
  - Accept pushes at the tail with live=1.
- Arbitration per cycle:
  1. ALU has priority. If alu_valid && alu_rd!=0, the ALU result is selected and no pop occurs.
  2. Otherwise, if the FIFO is non-empty, the head is popped. A live head is selected for write; a dead head is discarded with regwrite=0 next cycle.
  3. Otherwise regwrite=0 next cycle.
- WAW kill. An ALU result is younger than every buffered load, and younger than a load accepted in the same cycle.
  - A selected ALU write to register r clears live on every FIFO entry with rd==r.
  - A load accepted that same cycle with mem_rd==r is accepted and dropped, not enqueued.
- Simultaneous push and pop is allowed and fifo_count is unchanged. Pointers wrap modulo DEPTH.
- alu_stall = (fifo_count == DEPTH).
  - Upstream must drive alu_valid=0 while alu_stall=1.
  - If violated, the ALU still wins and the FIFO waits; nothing is lost, because mem_ready=0.
- busy_rsX=1 when query_rsX!=0 and either:
  - any live FIFO entry has rd==query_rsX, or
  - regwrite=1 && write_reg==query_rsX.
  busy is combinational from registered state plus the query input.
- Data is passed through unmodified at full DATA_W; no arithmetic.

Decomposition:
- Shared package (rv_pkg):
  - constants DATA_W=32, ADDR_W=5, REG_ZERO=0;
  - typedef wb_entry_t {logic live; logic [ADDR_W-1:0] rd; logic [DATA_W-1:0] data}.
- One sub-module, wb_fifo:
  - DEPTH-entry circular buffer;
  - per-entry kill-by-rd compare (kill_en, kill_rd);
  - two CAM match outputs for the busy queries.
- The top level holds the arbitration and output registers.

Test Plan:
- ALU alu_valid=1, alu_rd=3, alu_data=0xDEADBEEF with FIFO empty -> next cycle regwrite=1, write_reg=3, write_data=0xDEADBEEF, then regwrite=0; alu_rd=0 -> regwrite stays 0.
- Loads to x5=0x55, x6=0x66, x7=0x77, x8=0x88 pushed while ALU busy every cycle -> fifo_count=4, mem_ready=0, alu_stall=1. Drop ALU -> writes x5, x6, x7, x8 on 4 consecutive cycles in order; mem_ready returns to 1 the cycle after the first pop.
- Load x9=0x1 buffered, then ALU x9=0x2 -> busy_rs1 (query=9) stays 1 until the ALU write output. Dead entry popped with regwrite=0. Final register file x9=0x2, never 0x1.
- Same cycle: load x4=0xA accepted and ALU x4=0xB -> only write_reg=4, write_data=0xB; fifo_count unchanged.
- Three loads buffered, assert reset mid-drain -> regwrite=0 and fifo_count=0 immediately (async); no further writes after release.
- Query: load x10 pending, query_rs1=10, query_rs2=0 -> busy_rs1=1, busy_rs2=0; after the write completes -> both 0.
